// File: rtl/deserializer.sv
// deserializer
//   1:WIDTH serial-to-parallel converter. Collects each contiguous run of
//   WIDTH valid serial bits into one parallel word and presents it with a
//   one-cycle strobe. A gap in validIn part-way through a word abandons the
//   partial word and raises a one-cycle frameErr strobe.
//
// Parameters
//   WIDTH      parallel word width (>= 2)
//   MSB_FIRST  1: first received bit ends up in dataout[WIDTH-1]
//              0: first received bit ends up in dataout[0]
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   datain    serial data bit, sampled when validIn=1
//   validIn   serial bit valid
//   dataout   last completed word (held until the next one completes)
//   validOut  one-cycle strobe: dataout carries a new word
//   frameErr  one-cycle strobe: partial word discarded
//   busy      a word is partially received
module deserializer #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             datain,
    input  logic             validIn,
    output logic [WIDTH-1:0] dataout,
    output logic             validOut,
    output logic             frameErr,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             vo_nxt, fe_nxt;
    logic [WIDTH-1:0] shifted;

    // Shift register with the current input bit appended; on the last bit
    // this is exactly the completed word, so it feeds dataout directly.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sreg[WIDTH-2:0], datain};
        end else begin : g_lsb
            assign shifted = {datain, sreg[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        dout_nxt  = dataout;
        vo_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (validIn) begin
                    sreg_nxt  = shifted;
                    cnt_nxt   = CW'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (validIn) begin
                    sreg_nxt = shifted;
                    if (cnt == LAST) begin
                        // Completion returns to IDLE so the next valid bit
                        // starts a new word with no lost cycle.
                        dout_nxt  = shifted;
                        vo_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end else begin
                    // In SHIFT the count is always non-zero, so any gap here
                    // breaks a word.
                    fe_nxt    = 1'b1;
                    sreg_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            dataout  <= '0;
            validOut <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            state    <= state_nxt;
            sreg     <= sreg_nxt;
            cnt      <= cnt_nxt;
            dataout  <= dout_nxt;
            validOut <= vo_nxt;
            frameErr <= fe_nxt;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- 1:WIDTH serial-to-parallel converter. Sits directly downstream of the 32:1 serializer and consumes its `dataout`/`validOut` bit stream.
- Reassembles each contiguous run of WIDTH valid bits into one parallel word and presents it with a single-cycle strobe.
- Flags streams that break mid-word and discards the partial word.

Parameters:
- WIDTH, 32, parallel word width in bits (>=2).
- MSB_FIRST, 1, 1: first received bit lands in `dataout[WIDTH-1]`; 0: first received bit lands in `dataout[0]`.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- datain  input  1  serial data bit; sampled only when `validIn`=1.
- validIn  input  1  high on every cycle carrying a valid serial bit (driven by the serializer's `validOut`).
- dataout  output  WIDTH  last completed parallel word.
- validOut  output  1  one-cycle strobe: `dataout` updated with a new word.
- frameErr  output  1  one-cycle strobe: partial word abandoned (gap mid-word).
- busy  output  1  high while a word is partially received (bit count != 0).

Behaviour:
- Interface: one clock (`clk`); reset is asynchronous and active-low (`rst_n`).
- Reset (`rst_n`=0, asserted asynchronously):
  - `dataout`=0, `validOut`=0, `frameErr`=0, `busy`=0.
  - Shift register cleared, bit counter=0, FSM=IDLE.
  - Reset mid-word discards the partial word with no `frameErr`.
- State: shift register `sreg[WIDTH-1:0]`, bit counter `cnt` of width clog2(WIDTH), FSM {IDLE, SHIFT}.
- IDLE:
  - `validIn`=1: capture bit 0, `cnt`<=1, go to SHIFT.
  - `validIn`=0: remain in IDLE.
- SHIFT, `validIn`=1:
  - Capture bit and increment `cnt`.
  - Capture for MSB_FIRST=1: `sreg`<={`sreg`[WIDTH-2:0], `datain`}.
  - Capture for MSB_FIRST=0: `sreg`<={`datain`, `sreg`[WIDTH-1:1]}.
- SHIFT, `validIn`=0 with `cnt`!=0 (gap mid-word):
  - `frameErr`<=1 for one cycle.
  - `sreg` contents discarded, `cnt`<=0, go to IDLE.
  - `dataout` is unchanged.
- Word completion (WIDTH-th bit sampled at edge E, `cnt`=WIDTH-1 and `validIn`=1):
  - At E, `dataout`<= the full assembled word, including the bit sampled at E.
  - At E, `validOut`<=1 for exactly one cycle.
  - `cnt`<=0; FSM goes to IDLE.
  - Latency: `validOut` is visible in the cycle after the last bit is presented.
- Back-to-back words:
  - If `validIn` stays high, the bit following the last bit of word N is bit 0 of word N+1.
  - It is accepted with no lost cycle: after completion, the next cycle's `validIn`=1 is handled as IDLE capture.
  - Completion is not treated as a gap; `frameErr` stays 0.
- Idle gaps between complete words (`cnt`=0) are legal; no error.
- `dataout` holds its value indefinitely until the next completed word. It never shows partial data.
- `validOut` and `frameErr` are never high in the same cycle. Both are registered outputs.
- `busy`=1 exactly when FSM=SHIFT.
- Counter wrap: `cnt` never exceeds WIDTH-1; it returns to 0 on completion.

Test Plan:
- Reset, then `validIn`=0 for 10 cycles -> `dataout`=0, `validOut`=0, `frameErr`=0, `busy`=0 throughout.
- Serializer-style stream of 32'h56AB8312, MSB first, 32 contiguous valid cycles -> one `validOut` pulse one cycle after the last bit; `dataout`=32'h56AB8312 held afterwards.
- Back-to-back 32'h56AB8312 then 32'hA6B2C9D3 with `validIn` continuously high for 64 cycles -> two `validOut` pulses exactly 32 cycles apart.
  - Values: `dataout`=32'h56AB8312, then 32'hA6B2C9D3.
  - No `frameErr`.
- Stream 10 bits of 32'hFFFFFFFF, drop `validIn` for 1 cycle, then send full 32'h12345678 -> one `frameErr` pulse on the gap; `dataout` keeps its prior value; then `validOut` with `dataout`=32'h12345678.
- Assert `rst_n`=0 asynchronously (between clock edges) after 20 bits of a word, release, then send full 32'hCAFEBABE.
  - On reset: all outputs 0 immediately and no `frameErr`.
  - Afterwards: `dataout`=32'hCAFEBABE with a single `validOut` pulse.
- MSB_FIRST=0, WIDTH=8: send bits 0,1,0,0,1,0,1,1 in order -> `dataout`=8'hD2, single `validOut` pulse.
